// File: rtl/evp_horner_eval_if.sv
// Handshake/bus bundle between the EVP Horner stage and its FIFOs, coefficient RAM and firing FSM.
// master = the evaluation stage, slave = the surrounding environment.
interface evp_horner_eval_if #(
  parameter int unsigned word_size = 16
);
  logic                 start_evp;
  logic [2:0]           arg1;
  logic [3:0]           degree;
  logic [word_size-1:0] data_in;
  logic                 in_empty;
  logic                 rd_in_data;
  logic [6:0]           coef_addr;
  logic                 coef_rd_en;
  logic [word_size-1:0] coef_data;
  logic                 out_full;
  logic                 wr_out_result;
  logic                 wr_out_status;
  logic [word_size-1:0] data_out;
  logic [1:0]           status_out;
  logic                 busy;
  logic                 done_evp;

  modport master (
    input  start_evp, arg1, degree, data_in, in_empty, coef_data, out_full,
    output rd_in_data, coef_addr, coef_rd_en, wr_out_result, wr_out_status,
           data_out, status_out, busy, done_evp
  );

  modport slave (
    output start_evp, arg1, degree, data_in, in_empty, coef_data, out_full,
    input  rd_in_data, coef_addr, coef_rd_en, wr_out_result, wr_out_status,
           data_out, status_out, busy, done_evp
  );
endinterface

// File: rtl/evp_horner_eval.sv
// EVP firing-mode execution stage: pops x, streams coefficients c[N]..c[0] from RAM and
// evaluates the polynomial by Horner's method, pushing result and overflow status.
module evp_horner_eval #(
  parameter int unsigned word_size = 16
) (
  input logic               clk,
  input logic               rst,
  evp_horner_eval_if.master bus
);
  localparam int unsigned FW = 2 * word_size + 1;

  typedef enum logic [2:0] {IDLE, WAIT_X, LOAD, MAC, WRITE, DONE} state_t;

  state_t               state, state_nx;
  logic [2:0]           slot;
  logic [3:0]           idx;
  logic [3:0]           rd_idx;
  logic [word_size-1:0] acc;
  logic [word_size-1:0] x;
  logic                 ovf;
  logic [word_size-1:0] held_data;
  logic [1:0]           held_status;
  logic                 wr;
  logic [FW-1:0]        full;
  logic                 full_ovf;

  // Sign-extend every operand to FW bits; the low FW bits of the product are exact.
  always_comb begin
    full = {{(word_size + 1){acc[word_size-1]}}, acc}
         * {{(word_size + 1){x[word_size-1]}}, x}
         + {{(word_size + 1){bus.coef_data[word_size-1]}}, bus.coef_data};
    full_ovf = !((&full[FW-1:word_size-1]) || !(|full[FW-1:word_size-1]));
  end

  always_comb begin
    state_nx       = state;
    bus.rd_in_data = 1'b0;
    bus.coef_rd_en = 1'b0;
    rd_idx         = idx;
    wr             = 1'b0;
    bus.done_evp   = 1'b0;
    bus.busy       = (state != IDLE);
    case (state)
      IDLE:   if (bus.start_evp) state_nx = WAIT_X;
      WAIT_X: begin
        if (!bus.in_empty) begin
          bus.rd_in_data = 1'b1;
          bus.coef_rd_en = 1'b1;
          state_nx       = LOAD;
        end
      end
      LOAD, MAC: begin
        if (idx == 4'd0) begin
          state_nx = WRITE;
        end else begin
          bus.coef_rd_en = 1'b1;
          rd_idx         = 4'(idx - 4'd1);
          state_nx       = MAC;
        end
      end
      WRITE: begin
        if (!bus.out_full) begin
          wr       = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.done_evp = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address always carries the latched slot, so it can never stray into another polynomial.
  assign bus.coef_addr     = {slot, rd_idx};
  assign bus.wr_out_result = wr;
  assign bus.wr_out_status = wr;
  assign bus.data_out      = wr ? acc : held_data;
  assign bus.status_out    = wr ? {1'b0, ovf} : held_status;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      slot        <= '0;
      idx         <= '0;
      acc         <= '0;
      x           <= '0;
      ovf         <= 1'b0;
      held_data   <= '0;
      held_status <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.start_evp) begin
            slot <= bus.arg1;
            idx  <= bus.degree;
            ovf  <= 1'b0;
          end
        end
        WAIT_X: if (!bus.in_empty) x <= bus.data_in;
        LOAD: begin
          acc <= bus.coef_data;
          if (idx != 4'd0) idx <= 4'(idx - 4'd1);
        end
        MAC: begin
          acc <= full[word_size-1:0];
          ovf <= ovf | full_ovf;
          if (idx != 4'd0) idx <= 4'(idx - 4'd1);
        end
        WRITE: begin
          if (!bus.out_full) begin
            held_data   <= acc;
            held_status <= {1'b0, ovf};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_evp_horner_eval.sv
// Bench for evp_horner_eval: directed spec cases plus randomized firings checked
// against an arithmetic Horner model with FIFO/RAM behavioural models.
module tb_evp_horner_eval;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  evp_horner_eval_if #(.word_size(W)) bus();
  evp_horner_eval #(.word_size(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [W-1:0] mem [0:127];
  logic [W-1:0] xbuf [0:15];
  int unsigned  x_wr = 0;
  int unsigned  x_rd = 0;
  logic         hold_empty = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   arg1 = '0;
  logic [3:0]   deg = '0;
  logic         out_full = 1'b0;
  logic [W-1:0] coef_q = '0;
  int           cyc = 0;

  assign bus.start_evp = start;
  assign bus.arg1      = arg1;
  assign bus.degree    = deg;
  assign bus.in_empty  = hold_empty || (x_wr == x_rd);
  assign bus.data_in   = xbuf[x_rd[3:0]];
  assign bus.coef_data = coef_q;
  assign bus.out_full  = out_full;

  // Registered-read RAM and FWFT input FIFO pointer.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.coef_rd_en) coef_q <= mem[bus.coef_addr];
    if (bus.rd_in_data && !bus.in_empty) x_rd <= x_rd + 1;
  end

  logic [6:0]   addr_q [$];
  logic [W-1:0] res_q [$];
  logic [1:0]   st_q [$];
  int unsigned  pushes = 0, dones = 0, skew = 0, bad_wr = 0;
  int           done_cyc = 0;

  always @(negedge clk) begin
    if (bus.coef_rd_en) addr_q.push_back(bus.coef_addr);
    if (bus.wr_out_result) begin
      pushes++;
      res_q.push_back(bus.data_out);
      st_q.push_back(bus.status_out);
    end
    if (bus.wr_out_result !== bus.wr_out_status) skew++;
    if ((bus.wr_out_result || bus.wr_out_status) && out_full) bad_wr++;
    if (bus.done_evp) begin
      dones++;
      done_cyc = cyc;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {1'b0, bus.busy, bus.done_evp, bus.rd_in_data, bus.coef_rd_en, bus.wr_out_result,
            bus.wr_out_status, bus.status_out, bus.coef_addr, bus.data_out};
  endfunction

  // Horner evaluation with wide integer arithmetic, wrapping to W bits each step.
  function automatic void model(input int slot, input int d, input logic [W-1:0] x,
                                output logic [W-1:0] r, output logic [1:0] st);
    longint acc, xs, full, c;
    logic [6:0] a;
    bit ov;
    ov = 1'b0;
    xs = longint'($signed(x));
    a = 7'(slot * 16 + d);
    acc = longint'($signed(mem[a]));
    for (int k = d - 1; k >= 0; k--) begin
      a = 7'(slot * 16 + k);
      c = longint'($signed(mem[a]));
      full = acc * xs + c;
      if (full > 32767 || full < -32768) ov = 1'b1;
      acc = longint'($signed(full[15:0]));
    end
    r = acc[15:0];
    st = {1'b0, ov};
  endfunction

  task automatic run(input int slot, input int d, input logic [W-1:0] x, input int in_stall,
                     input int out_stall, input bit dup, input string tag);
    logic [W-1:0] er, lr;
    logic [1:0]   es, ls;
    int unsigned  p0, q0, a0, dn0, sk0, bw0, abad;
    int           t0, lim;
    model(slot, d, x, er, es);
    p0 = x_rd; q0 = pushes; a0 = addr_q.size(); dn0 = dones; sk0 = skew; bw0 = bad_wr;
    xbuf[x_wr[3:0]] = x;
    hold_empty = (in_stall != 0);
    out_full = (out_stall != 0);
    x_wr++;
    @(posedge clk); #1;
    start = 1'b1; arg1 = 3'(slot); deg = 4'(d); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (dup) begin
      start = 1'b1; arg1 = 3'(slot + 1); deg = 4'd9;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (in_stall) begin
      chk({tag, " stall busy"}, 32'(bus.busy), 1);
      chk({tag, " stall no pop"}, 32'(bus.rd_in_data), 0);
      @(posedge clk); #1;
    end
    hold_empty = 1'b0;
    if (out_stall != 0) begin
      while (cyc < t0 + 3 + d + in_stall + out_stall) begin
        @(posedge clk); #1;
      end
      out_full = 1'b0;
    end
    lim = 0;
    while (dones == dn0 && lim < 200) begin
      @(posedge clk); #1;
      lim++;
    end
    chk({tag, " done count"}, dones - dn0, 1);
    chk({tag, " latency"}, 32'(done_cyc - t0), 32'(d + 4 + in_stall + out_stall));
    chk({tag, " pops"}, x_rd - p0, 1);
    chk({tag, " pushes"}, pushes - q0, 1);
    chk({tag, " reads"}, 32'(addr_q.size()) - a0, 32'(d + 1));
    abad = 0;
    for (int i = 0; i <= d && a0 + i < addr_q.size(); i++)
      if (addr_q[a0 + i] !== 7'(slot * 16 + d - i)) abad++;
    chk({tag, " addr seq"}, abad, 0);
    lr = (res_q.size() > 0) ? res_q[res_q.size() - 1] : 'x;
    ls = (st_q.size() > 0) ? st_q[st_q.size() - 1] : 'x;
    chk({tag, " result"}, 32'(lr), 32'(er));
    chk({tag, " status"}, 32'(ls), 32'(es));
    chk({tag, " strobe skew/full"}, (skew - sk0) + (bad_wr - bw0), 0);
    chk({tag, " idle hold"}, {13'b0, bus.busy, bus.status_out, bus.data_out}, {15'b0, es, er});
  endtask

  initial begin
    logic [W-1:0] rv;
    int s, d;
    for (int i = 0; i < 128; i++) mem[i] = W'($urandom);
    for (int i = 0; i < 16; i++) xbuf[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", outs_vec(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", outs_vec(), 0);

    mem[7'h20] = 16'd1; mem[7'h21] = 16'd2; mem[7'h22] = 16'd3;
    run(2, 2, 16'd2, 0, 0, 0, "c1");
    chk("c1 spec value", 32'(res_q[res_q.size() - 1]), 17);

    mem[7'h00] = 16'hFFFB;
    run(0, 0, 16'd100, 0, 0, 0, "c2");
    chk("c2 spec value", 32'(res_q[res_q.size() - 1]), 32'hFFFB);

    mem[7'h31] = 16'h4000; mem[7'h30] = 16'h0000;
    run(3, 1, 16'd4, 0, 0, 0, "c3pos");
    chk("c3pos spec status", 32'(st_q[st_q.size() - 1]), 1);
    mem[7'h31] = 16'hFFFF;
    run(3, 1, 16'h8000, 0, 0, 0, "c3neg");
    chk("c3neg spec status", 32'(st_q[st_q.size() - 1]), 1);

    run(2, 2, 16'd2, 5, 0, 0, "c4");
    run(2, 2, 16'd2, 0, 3, 0, "c5");

    begin : mid_reset
      int unsigned q0, dn0;
      q0 = pushes; dn0 = dones;
      xbuf[x_wr[3:0]] = 16'd3;
      x_wr++;
      @(posedge clk); #1;
      start = 1'b1; arg1 = 3'd4; deg = 4'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("c6 in MAC busy", 32'(bus.busy), 1);
      rst = 1'b0;
      #1;
      chk("c6 reset outputs", outs_vec(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("c6 no push/done", (pushes - q0) + (dones - dn0), 0);
      chk("c6 idle after", outs_vec(), 0);
    end
    run(2, 2, 16'd2, 0, 0, 1, "c6 restart");

    for (int n = 0; n < 10; n++) begin
      s = int'($urandom_range(7));
      d = int'($urandom_range(15));
      for (int k = 0; k < 16; k++) begin
        rv = W'($urandom);
        if (n % 2 == 0) rv = W'($signed(4'(rv)));
        mem[7'(s * 16 + k)] = rv;
      end
      rv = W'($urandom);
      if (n % 3 != 2) rv = W'($signed(3'(rv)));
      run(s, d, rv, int'($urandom_range(2)), int'($urandom_range(2)), 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
